// File: rtl/pipeline_3_memacc_pkg.sv
// Shared definitions for the pipeline memory-access stage: opcode values,
// control-word field positions and the memory-access FSM state type.
package pipe_pkg;

  // Opcodes that touch the data RAM
  localparam logic [2:0] OP_LDR = 3'b011;
  localparam logic [2:0] OP_STR = 3'b100;

  // Control-word field positions
  localparam int OPC_HI  = 21;
  localparam int OPC_LO  = 19;
  localparam int WE_BIT  = 3;
  localparam int WNUM_HI = 2;
  localparam int WNUM_LO = 0;

  // RUN: instruction flows through; WAIT: access outstanding, pipeline stalled
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } memacc_state_e;

endpackage

// File: rtl/pipeline_3_memacc_if.sv
// Data-RAM request bus between the memory-access stage (master) and the
// synchronous data RAM (slave). mem_ready accepts the access in the cycle
// it is high; read data appears on the RAM output register one cycle later.
interface pipeline_3_memacc_if #(
  parameter int DATA_W = 16
) ();

  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic              mem_ready;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_read,
    output mem_write,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_read,
    input  mem_write,
    output mem_ready
  );

endinterface

// File: rtl/pipeline_3_memacc_timeout.sv
// Watchdog for an outstanding data-RAM access. Counts WAIT cycles and
// signals expiry when the count reaches TIMEOUT_CYCLES-1 without mem_ready.
// Only instantiated when MEMACC_TIMEOUT_EN is defined.
module memacc_timeout #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic in_wait_i,
  input  logic ready_i,
  output logic expire_o,
  output logic fault_o
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q;
  logic          fault_q;

  assign expire_o = in_wait_i && !ready_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign fault_o  = fault_q;

  // Counter held at zero outside WAIT so it starts from zero on every entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!in_wait_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Fault flag is sticky until reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_q <= 1'b0;
    end else if (expire_o) begin
      fault_q <= 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_3_memacc.sv
// Memory-access stage (stage 3) of the 5-stage 16-bit pipeline.
// Captures the execute bundle, issues LDR/STR to the data RAM over the
// request bus, stalls the whole pipeline (fetch_next_out low) while an access
// is outstanding and presents a bubble to writeback until it completes.
// Optional watchdog: define MEMACC_TIMEOUT_EN to bound WAIT and add mem_fault.
module pipeline_3_memacc
  import pipe_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int CTRL_W         = 22,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CTRL_W-1:0]    control_in,
  input  logic [DATA_W-1:0]    result_in,
  input  logic [DATA_W-1:0]    sdata_in,
  input  logic [DATA_W-1:0]    delayed_B_in,
  input  logic                 do_delayed_B_in,
  input  logic                 flush_in,
  pipeline_3_memacc_if.master  mem,
  output logic [CTRL_W-1:0]    control_out,
  output logic [DATA_W-1:0]    result_out,
  output logic [DATA_W-1:0]    delayed_B_out,
  output logic                 do_delayed_B_out,
  output logic                 fetch_next_out
`ifdef MEMACC_TIMEOUT_EN
  ,
  output logic                 mem_fault
`endif
);

  // Captured execute bundle
  logic [CTRL_W-1:0] ctrl_q;
  logic              ddb_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] sdata_q;
  logic [DATA_W-1:0] db_q;

  // FSM
  memacc_state_e state_q, state_d;
  logic          flushed_q, flushed_d;

  logic          fetch_next;
  logic          bubble;
  logic          req;
  logic          timeout_expire;
  logic [2:0]    opcode;
  logic          is_ldr, is_str, is_mem;

  assign opcode = ctrl_q[OPC_HI:OPC_LO];
  assign is_ldr = (opcode == OP_LDR);
  assign is_str = (opcode == OP_STR);
  assign is_mem = is_ldr | is_str;

`ifdef MEMACC_TIMEOUT_EN
  memacc_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .in_wait_i (state_q == ST_WAIT),
    .ready_i   (mem.mem_ready),
    .expire_o  (timeout_expire),
    .fault_o   (mem_fault)
  );
`else
  assign timeout_expire = 1'b0;
`endif

  // Control side of the input register: a flush loads a NOP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // pre-edge values regardless of statement order.
      ctrl_q <= '0;
      ddb_q  <= 1'b0;
    end else if (fetch_next) begin
      ctrl_q <= flush_in ? '0 : control_in;
      ddb_q  <= flush_in ? 1'b0 : do_delayed_B_in;
    end
  end

  // Data side of the input register
  // NOTE: data fields carry no reset; they are only observed alongside a
  // valid control word, which is cleared on reset.
  always_ff @(posedge clk) begin
    if (fetch_next) begin
      result_q <= result_in;
      sdata_q  <= sdata_in;
      db_q     <= delayed_B_in;
    end
  end

  // Next-state, stall and bubble decode for the access handshake
  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_d    = state_q;
    flushed_d  = flushed_q;
    req        = 1'b0;
    fetch_next = 1'b1;
    bubble     = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (flush_in) begin
          // Squash the captured instruction before it reaches the RAM
          bubble = 1'b1;
        end else if (is_mem) begin
          req = 1'b1;
          if (!mem.mem_ready) begin
            fetch_next = 1'b0;
            bubble     = 1'b1;
            flushed_d  = 1'b0;
            state_d    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // The access cannot be aborted; only its writeback is squashed
        req = 1'b1;
        if (mem.mem_ready) begin
          bubble    = flushed_q | flush_in;
          flushed_d = 1'b0;
          state_d   = ST_RUN;
        end else if (timeout_expire) begin
          bubble    = 1'b1;
          flushed_d = 1'b0;
          state_d   = ST_RUN;
        end else begin
          fetch_next = 1'b0;
          bubble     = 1'b1;
          flushed_d  = flushed_q | flush_in;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // FSM state and pending-flush flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flushed_q <= flushed_d;
    end
  end

  assign mem.mem_read      = req & is_ldr;
  assign mem.mem_write     = req & is_str;
  assign mem.mem_addr      = result_q;
  assign mem.mem_wdata     = sdata_q;

  assign fetch_next_out    = fetch_next;
  assign control_out       = bubble ? '0 : ctrl_q;
  assign do_delayed_B_out  = ddb_q & ~bubble;
  assign result_out        = result_q;
  assign delayed_B_out     = db_q;

endmodule

// File: tb/tb_pipeline_3_memacc.sv
// Directed self-checking bench for pipeline_3_memacc. Inputs change 1 ns
// after the rising edge; outputs are sampled on the falling edge.
// With MEMACC_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYCLES = 8
// and the watchdog scenario is exercised as well.
module tb_pipeline_3_memacc;

  // Control words: opcode in [21:19]
  localparam logic [21:0] W_LDR = 22'h18000A; // 011, we=1, wnum=2
  localparam logic [21:0] W_STR = 22'h200010; // 100
  localparam logic [21:0] W_ALU = 22'h08000B; // 001, we=1, wnum=3

  logic        clk = 1'b0;
  logic        rst;
  logic [21:0] control_in;
  logic [15:0] result_in, sdata_in, delayed_B_in;
  logic        do_delayed_B_in, flush_in;
  logic [21:0] control_out;
  logic [15:0] result_out, delayed_B_out;
  logic        do_delayed_B_out, fetch_next_out;
  logic        mem_fault;

  int n_cmp = 0;
  int n_err = 0;

  pipeline_3_memacc_if #(.DATA_W(16)) bus ();

  pipeline_3_memacc #(
    .DATA_W(16), .CTRL_W(22), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .control_in       (control_in),
    .result_in        (result_in),
    .sdata_in         (sdata_in),
    .delayed_B_in     (delayed_B_in),
    .do_delayed_B_in  (do_delayed_B_in),
    .flush_in         (flush_in),
    .mem              (bus),
    .control_out      (control_out),
    .result_out       (result_out),
    .delayed_B_out    (delayed_B_out),
    .do_delayed_B_out (do_delayed_B_out),
    .fetch_next_out   (fetch_next_out)
`ifdef MEMACC_TIMEOUT_EN
    ,
    .mem_fault        (mem_fault)
`endif
  );

`ifndef MEMACC_TIMEOUT_EN
  assign mem_fault = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    control_in      = '0;
    result_in       = '0;
    sdata_in        = '0;
    delayed_B_in    = '0;
    do_delayed_B_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    flush_in = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.mem_read !== 1'b0) begin n_err++; $display("FAIL rst_read: got %b want 0", bus.mem_read); end
    n_cmp++; if (bus.mem_write !== 1'b0) begin n_err++; $display("FAIL rst_write: got %b want 0", bus.mem_write); end
    n_cmp++; if (control_out !== 22'h0) begin n_err++; $display("FAIL rst_ctrl: got %h want 0", control_out); end
    n_cmp++; if (do_delayed_B_out !== 1'b0) begin n_err++; $display("FAIL rst_ddb: got %b want 0", do_delayed_B_out); end
    n_cmp++; if (fetch_next_out !== 1'b1) begin n_err++; $display("FAIL rst_fetch: got %b want 1", fetch_next_out); end
`ifdef MEMACC_TIMEOUT_EN
    n_cmp++; if (mem_fault !== 1'b0) begin n_err++; $display("FAIL rst_fault: got %b want 0", mem_fault); end
`endif
    tick();
    rst = 1'b1;
  endtask

  task automatic test_ldr_ready();
    tick();
    control_in = W_LDR; result_in = 16'h0040; bus.mem_ready = 1'b1;
    tick();
    clear_inputs();
    @(negedge clk);
    n_cmp++; if (bus.mem_read !== 1'b1) begin n_err++; $display("FAIL ldr_read: got %b want 1", bus.mem_read); end
    n_cmp++; if (bus.mem_write !== 1'b0) begin n_err++; $display("FAIL ldr_write: got %b want 0", bus.mem_write); end
    n_cmp++; if (bus.mem_addr !== 16'h0040) begin n_err++; $display("FAIL ldr_addr: got %h want 0040", bus.mem_addr); end
    n_cmp++; if (fetch_next_out !== 1'b1) begin n_err++; $display("FAIL ldr_fetch: got %b want 1", fetch_next_out); end
    n_cmp++; if (control_out !== W_LDR) begin n_err++; $display("FAIL ldr_ctrl: got %h want %h", control_out, W_LDR); end
    tick();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.mem_read !== 1'b0) begin n_err++; $display("FAIL ldr_read_drop: got %b want 0", bus.mem_read); end
    n_cmp++; if (control_out !== 22'h0) begin n_err++; $display("FAIL ldr_next_nop: got %h want 0", control_out); end
  endtask

  task automatic test_str_wait();
    tick();
    control_in = W_STR; result_in = 16'h0123; sdata_in = 16'hBEEF; bus.mem_ready = 1'b0;
    tick();
    clear_inputs();
    result_in = 16'h2222; sdata_in = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (fetch_next_out !== 1'b0) begin n_err++; $display("FAIL str_stall_fetch[%0d]: got %b want 0", i, fetch_next_out); end
      n_cmp++; if (control_out !== 22'h0) begin n_err++; $display("FAIL str_stall_ctrl[%0d]: got %h want 0", i, control_out); end
      n_cmp++; if (bus.mem_write !== 1'b1) begin n_err++; $display("FAIL str_stall_write[%0d]: got %b want 1", i, bus.mem_write); end
      n_cmp++; if (bus.mem_wdata !== 16'hBEEF) begin n_err++; $display("FAIL str_wdata[%0d]: got %h want BEEF", i, bus.mem_wdata); end
      n_cmp++; if (bus.mem_addr !== 16'h0123) begin n_err++; $display("FAIL str_addr[%0d]: got %h want 0123", i, bus.mem_addr); end
      tick();
      if (i == 2) bus.mem_ready = 1'b1;
    end
    @(negedge clk);
    n_cmp++; if (fetch_next_out !== 1'b1) begin n_err++; $display("FAIL str_done_fetch: got %b want 1", fetch_next_out); end
    n_cmp++; if (control_out !== W_STR) begin n_err++; $display("FAIL str_done_ctrl: got %h want %h", control_out, W_STR); end
    n_cmp++; if (bus.mem_write !== 1'b1) begin n_err++; $display("FAIL str_done_write: got %b want 1", bus.mem_write); end
    tick();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.mem_write !== 1'b0) begin n_err++; $display("FAIL str_write_drop: got %b want 0", bus.mem_write); end
    n_cmp++; if (control_out !== 22'h0) begin n_err++; $display("FAIL str_next_nop: got %h want 0", control_out); end
    n_cmp++; if (result_out !== 16'h2222) begin n_err++; $display("FAIL str_held_input: got %h want 2222", result_out); end
  endtask

  task automatic test_flush_wait();
    tick();
    control_in = W_LDR; result_in = 16'h0080; bus.mem_ready = 1'b0;
    tick();
    clear_inputs();
    @(negedge clk);
    n_cmp++; if (fetch_next_out !== 1'b0) begin n_err++; $display("FAIL fw_stall: got %b want 0", fetch_next_out); end
    tick();
    flush_in = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.mem_read !== 1'b1) begin n_err++; $display("FAIL fw_not_aborted: got %b want 1", bus.mem_read); end
    n_cmp++; if (fetch_next_out !== 1'b0) begin n_err++; $display("FAIL fw_flush_stall: got %b want 0", fetch_next_out); end
    tick();
    flush_in = 1'b0; bus.mem_ready = 1'b1;
    control_in = W_ALU; result_in = 16'h0055;
    @(negedge clk);
    n_cmp++; if (fetch_next_out !== 1'b1) begin n_err++; $display("FAIL fw_done_fetch: got %b want 1", fetch_next_out); end
    n_cmp++; if (control_out !== 22'h0) begin n_err++; $display("FAIL fw_done_ctrl: got %h want 0", control_out); end
    n_cmp++; if (bus.mem_read !== 1'b1) begin n_err++; $display("FAIL fw_done_read: got %b want 1", bus.mem_read); end
    tick();
    bus.mem_ready = 1'b0;
    clear_inputs();
    @(negedge clk);
    n_cmp++; if (control_out !== W_ALU) begin n_err++; $display("FAIL fw_next_ctrl: got %h want %h", control_out, W_ALU); end
    n_cmp++; if (result_out !== 16'h0055) begin n_err++; $display("FAIL fw_next_result: got %h want 0055", result_out); end
    n_cmp++; if (bus.mem_read !== 1'b0) begin n_err++; $display("FAIL fw_next_read: got %b want 0", bus.mem_read); end
  endtask

  task automatic test_delayed_b();
    tick();
    control_in = W_ALU; delayed_B_in = 16'h1234; do_delayed_B_in = 1'b1;
    tick();
    clear_inputs();
    @(negedge clk);
    n_cmp++; if (do_delayed_B_out !== 1'b1) begin n_err++; $display("FAIL db_alu_do: got %b want 1", do_delayed_B_out); end
    n_cmp++; if (delayed_B_out !== 16'h1234) begin n_err++; $display("FAIL db_alu_tgt: got %h want 1234", delayed_B_out); end
    tick();
    control_in = W_STR; result_in = 16'h0200; delayed_B_in = 16'h0ABC; do_delayed_B_in = 1'b1;
    bus.mem_ready = 1'b0;
    tick();
    clear_inputs();
    @(negedge clk);
    n_cmp++; if (do_delayed_B_out !== 1'b0) begin n_err++; $display("FAIL db_stall1: got %b want 0", do_delayed_B_out); end
    tick();
    @(negedge clk);
    n_cmp++; if (do_delayed_B_out !== 1'b0) begin n_err++; $display("FAIL db_stall2: got %b want 0", do_delayed_B_out); end
    n_cmp++; if (delayed_B_out !== 16'h0ABC) begin n_err++; $display("FAIL db_str_tgt: got %h want 0ABC", delayed_B_out); end
    tick();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (do_delayed_B_out !== 1'b1) begin n_err++; $display("FAIL db_done: got %b want 1", do_delayed_B_out); end
    n_cmp++; if (control_out !== W_STR) begin n_err++; $display("FAIL db_done_ctrl: got %h want %h", control_out, W_STR); end
    tick();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (do_delayed_B_out !== 1'b0) begin n_err++; $display("FAIL db_after: got %b want 0", do_delayed_B_out); end
  endtask

  task automatic test_flush_run();
    tick();
    control_in = W_LDR; result_in = 16'h0300; bus.mem_ready = 1'b0;
    tick();
    clear_inputs();
    flush_in = 1'b1; control_in = W_ALU;
    @(negedge clk);
    n_cmp++; if (bus.mem_read !== 1'b0) begin n_err++; $display("FAIL fr_req_suppressed: got %b want 0", bus.mem_read); end
    n_cmp++; if (fetch_next_out !== 1'b1) begin n_err++; $display("FAIL fr_fetch: got %b want 1", fetch_next_out); end
    n_cmp++; if (control_out !== 22'h0) begin n_err++; $display("FAIL fr_ctrl: got %h want 0", control_out); end
    tick();
    flush_in = 1'b0; control_in = '0;
    @(negedge clk);
    n_cmp++; if (control_out !== 22'h0) begin n_err++; $display("FAIL fr_nop_loaded: got %h want 0", control_out); end
  endtask

  task automatic test_reset_wait();
    tick();
    control_in = W_STR; result_in = 16'h0400; sdata_in = 16'h5A5A; bus.mem_ready = 1'b0;
    tick();
    clear_inputs();
    tick();
    @(negedge clk);
    n_cmp++; if (bus.mem_write !== 1'b1) begin n_err++; $display("FAIL rw_in_wait: got %b want 1", bus.mem_write); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (bus.mem_write !== 1'b0) begin n_err++; $display("FAIL rw_async_write: got %b want 0", bus.mem_write); end
    n_cmp++; if (bus.mem_read !== 1'b0) begin n_err++; $display("FAIL rw_async_read: got %b want 0", bus.mem_read); end
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (control_out !== 22'h0) begin n_err++; $display("FAIL rw_ctrl: got %h want 0", control_out); end
    n_cmp++; if (fetch_next_out !== 1'b1) begin n_err++; $display("FAIL rw_fetch: got %b want 1", fetch_next_out); end
    tick();
    control_in = W_ALU; result_in = 16'h0777;
    tick();
    clear_inputs();
    @(negedge clk);
    n_cmp++; if (control_out !== W_ALU) begin n_err++; $display("FAIL rw_run_ctrl: got %h want %h", control_out, W_ALU); end
    n_cmp++; if (result_out !== 16'h0777) begin n_err++; $display("FAIL rw_run_result: got %h want 0777", result_out); end
  endtask

`ifdef MEMACC_TIMEOUT_EN
  task automatic test_timeout();
    tick();
    control_in = W_LDR; result_in = 16'h0900; bus.mem_ready = 1'b0;
    tick();
    clear_inputs();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++; if (fetch_next_out !== 1'b0) begin n_err++; $display("FAIL to_stall[%0d]: got %b want 0", i, fetch_next_out); end
      n_cmp++; if (mem_fault !== 1'b0) begin n_err++; $display("FAIL to_fault_early[%0d]: got %b want 0", i, mem_fault); end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (fetch_next_out !== 1'b1) begin n_err++; $display("FAIL to_expire_fetch: got %b want 1", fetch_next_out); end
    n_cmp++; if (control_out !== 22'h0) begin n_err++; $display("FAIL to_bubble: got %h want 0", control_out); end
    tick();
    @(negedge clk);
    n_cmp++; if (mem_fault !== 1'b1) begin n_err++; $display("FAIL to_fault: got %b want 1", mem_fault); end
    n_cmp++; if (bus.mem_read !== 1'b0) begin n_err++; $display("FAIL to_read_drop: got %b want 0", bus.mem_read); end
    n_cmp++; if (fetch_next_out !== 1'b1) begin n_err++; $display("FAIL to_fetch_run: got %b want 1", fetch_next_out); end
    tick();
    @(negedge clk);
    n_cmp++; if (mem_fault !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b want 1", mem_fault); end
  endtask
`endif

  initial begin
    test_reset();
    test_ldr_ready();
    test_str_wait();
    test_flush_wait();
    test_delayed_b();
    test_flush_run();
    test_reset_wait();
`ifdef MEMACC_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, bench did not finish");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/pipeline_3_memacc.md
Name: pipeline_3_memacc

Overview:
- Memory-access stage of the 5-stage 16-bit pipeline; sits between execute (stage 2) and register writeback (stage 4).
- Registers the execute bundle and issues LDR/STR accesses to the synchronous data RAM with a ready handshake.
- Generates the global fetch_next stall signal and passes control, result and delayed-branch state to writeback.
- Emits a bubble to writeback while an access is outstanding.

Parameters:
- DATA_W, 16, width of data, address and result.
- CTRL_W, 22, width of control word; opcode = [21:19], write enable = [3], writenum = [2:0].
- TIMEOUT_CYCLES, 64, watchdog limit for the optional feature.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- control_in  in  CTRL_W  control word from execute.
- result_in  in  DATA_W  ALU result; this is the address for LDR/STR.
- sdata_in  in  DATA_W  store data for STR.
- delayed_B_in  in  DATA_W  delayed-branch target from execute.
- do_delayed_B_in  in  1  delayed-branch request from execute.
- flush_in  in  1  synchronous squash of the captured instruction.
- mem_addr  out  DATA_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_read  out  1  read request.
- mem_write  out  1  write request.
- mem_ready  in  1  access accepted this cycle; RAM output register holds read data next cycle.
- control_out  out  CTRL_W  control word to writeback.
- result_out  out  DATA_W  result to writeback.
- delayed_B_out  out  DATA_W  delayed-branch target to writeback.
- do_delayed_B_out  out  1  delayed-branch request to writeback.
- fetch_next_out  out  1  global advance; low stalls all upstream stages.
- mem_fault  out  1  sticky timeout flag; present only with the optional feature.

Behaviour:
- Input register (control, result, sdata, delayed_B, do_delayed_B):
  - Loads on the rising edge when fetch_next_out = 1; holds otherwise.
  - Reset clears control and do_delayed_B to 0; data fields are not reset.
- flush_in = 1 with fetch_next_out = 1 loads control = 0 and do_delayed_B = 0 (NOP).
- is_ldr = opcode 3'b011; is_str = opcode 3'b100; is_mem = is_ldr | is_str.
- FSM states RUN and WAIT; reset state is RUN.
  - RUN, is_mem = 0: no request; fetch_next_out = 1; control_out = captured control.
  - RUN, is_mem = 1: mem_read = is_ldr, mem_write = is_str, mem_addr = result, mem_wdata = sdata.
    - mem_ready = 1: access completes this cycle; fetch_next_out = 1; control_out = captured control; stay in RUN.
    - mem_ready = 0: fetch_next_out = 0; control_out = 0; go to WAIT.
  - WAIT: request stays asserted with stable addr/wdata; fetch_next_out = 0; control_out = 0.
    - mem_ready = 1: fetch_next_out = 1; control_out = captured control; return to RUN.
- Completion cycle: writeback captures control on the same edge, and RAM rdata is valid the following cycle, aligned with writeback's control register.
- flush_in during WAIT:
  - The access is not aborted; the bus protocol requires completion.
  - A flushed flag is set; on completion control_out = 0 and do_delayed_B_out = 0.
  - The flag clears on completion.
- flush_in in RUN with a same-cycle access: the request is suppressed (mem_read = mem_write = 0) and the instruction is squashed.
- Outputs: result_out and delayed_B_out come from the captured registers; do_delayed_B_out = captured do_delayed_B, gated to 0 whenever control_out is a bubble.
- Reset values: mem_read, mem_write, control_out, do_delayed_B_out = 0; fetch_next_out = 1; mem_fault = 0.
- Reset asserted mid-WAIT drops the request immediately; no completion is reported.

Optional Feature:
- Macro: MEMACC_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entering WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES-1 without mem_ready: force return to RUN, emit a bubble, set mem_fault.
  - mem_fault is sticky until reset.
- Undefined: no counter, the mem_fault port is absent, and WAIT is unbounded.

Decomposition:
- Shared package pipe_pkg: opcode constants (OP_LDR = 3'b011, OP_STR = 3'b100), control field index constants, memacc state enum.
- Input register uses the existing enabled DFF cells.
- One natural sub-module, memacc_timeout (watchdog counter), instantiated only under MEMACC_TIMEOUT_EN.

Test Plan:
- LDR, result = 16'h0040, mem_ready high immediately -> mem_read = 1 and mem_addr = 16'h0040 for 1 cycle; fetch_next_out stays 1; control_out = LDR word the same cycle.
- STR, sdata = 16'hBEEF, mem_ready low 3 cycles then high -> fetch_next_out low 3 cycles; control_out = 0 for 3 cycles; mem_wdata = 16'hBEEF held stable; completion on cycle 4.
- flush_in during WAIT of an LDR -> access completes on mem_ready; control_out stays 0; next instruction proceeds normally.
- do_delayed_B_in = 1 on a non-mem op -> do_delayed_B_out = 1 and delayed_B_out = target one cycle after capture; with a stalled STR, do_delayed_B_out is held at 0 until completion.
- rst low mid-WAIT -> mem_read/mem_write drop asynchronously; after release FSM = RUN, control_out = 0, fetch_next_out = 1.
- MEMACC_TIMEOUT_EN, TIMEOUT_CYCLES = 8, mem_ready never asserted -> mem_fault rises after 8 WAIT cycles; fetch_next_out returns to 1; bubble emitted.
